// File: rtl/decode_prefix_stream.sv
// decode_prefix_stream: strips legacy x86 prefix bytes from an instruction
// window one byte per cycle and presents the unprefixed window together with
// the decoded prefix attributes on a valid/ready output.
module decode_prefix_stream #(
    parameter int WINDOW_BYTES = 12,
    parameter int MAX_PREFIXES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [8*WINDOW_BYTES-1:0]             in_window,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [8*WINDOW_BYTES-1:0]             out_window,
    output logic                                  out_operand_16bit,
    output logic                                  out_address_16bit,
    output logic [1:0]                            out_rep,
    output logic                                  out_lock,
    output logic [2:0]                            out_seg,
    output logic [$clog2(MAX_PREFIXES+1)-1:0]     out_prefix_count,
    output logic                                  out_error
);

    localparam int WW = 8 * WINDOW_BYTES;
    localparam int CW = $clog2(MAX_PREFIXES + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PREFIXES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e         state_q, state_d;

    logic [WW-1:0]  win_q, win_d;
    logic           op16_q, op16_d;
    logic           addr16_q, addr16_d;
    logic [1:0]     rep_q, rep_d;
    logic           lock_q, lock_d;
    logic [2:0]     seg_q, seg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;

    logic [7:0]     byte0;
    logic           byte0_is_prefix;
    logic           at_limit;
    logic           accept;
    logic           strip;

    // Classify the lowest window byte as a prefix or not.
    always_comb begin
        byte0 = win_q[7:0];
        case (byte0)
            8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3,
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: byte0_is_prefix = 1'b1;
            default:                                  byte0_is_prefix = 1'b0;
        endcase
    end

    assign at_limit = (cnt_q == MAX_CNT);
    assign accept   = in_valid & in_ready;
    assign strip    = (state_q == SCAN) & byte0_is_prefix & ~at_limit & ~flush;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = SCAN;
                SCAN: if (!(byte0_is_prefix && !at_limit)) state_d = HOLD;
                HOLD: begin
                    if (accept)         state_d = SCAN;
                    else if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs; in_ready in HOLD follows out_ready combinationally so a
    // retiring record can hand off to the next window without a bubble.
    always_comb begin
        in_ready  = ((state_q == IDLE) | ((state_q == HOLD) & out_ready)) & ~flush;
        out_valid = (state_q == HOLD);
    end

    // Datapath next state: load on accept, strip one prefix per SCAN cycle.
    always_comb begin
        win_d    = win_q;
        op16_d   = op16_q;
        addr16_d = addr16_q;
        rep_d    = rep_q;
        lock_d   = lock_q;
        seg_d    = seg_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (accept) begin
            win_d    = in_window;
            op16_d   = 1'b0;
            addr16_d = 1'b0;
            rep_d    = 2'b00;
            lock_d   = 1'b0;
            seg_d    = 3'd0;
            cnt_d    = '0;
            err_d    = 1'b0;
        end else if (strip) begin
            case (byte0)
                8'h66:   op16_d   = 1'b1;
                8'h67:   addr16_d = 1'b1;
                8'hF0:   lock_d   = 1'b1;
                8'hF3:   rep_d    = 2'b01;
                8'hF2:   rep_d    = 2'b10;
                8'h26:   seg_d    = 3'd1;
                8'h2E:   seg_d    = 3'd2;
                8'h36:   seg_d    = 3'd3;
                8'h3E:   seg_d    = 3'd4;
                8'h64:   seg_d    = 3'd5;
                8'h65:   seg_d    = 3'd6;
                default: ;
            endcase
            win_d = {8'h00, win_q[WW-1:8]};
            cnt_d = cnt_q + CW'(1);
        end else if ((state_q == SCAN) && byte0_is_prefix && at_limit && !flush) begin
            err_d = 1'b1;
        end
    end

    // Datapath registers; these drive the out_* fields directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q    <= '0;
            op16_q   <= 1'b0;
            addr16_q <= 1'b0;
            rep_q    <= 2'b00;
            lock_q   <= 1'b0;
            seg_q    <= 3'd0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            win_q    <= win_d;
            op16_q   <= op16_d;
            addr16_q <= addr16_d;
            rep_q    <= rep_d;
            lock_q   <= lock_d;
            seg_q    <= seg_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign out_window        = win_q;
    assign out_operand_16bit = op16_q;
    assign out_address_16bit = addr16_q;
    assign out_rep           = rep_q;
    assign out_lock          = lock_q;
    assign out_seg           = seg_q;
    assign out_prefix_count  = cnt_q;
    assign out_error         = err_q;

endmodule

// File: tb/tb_decode_prefix_stream.sv
// Testbench for decode_prefix_stream: scoreboard of expected records pushed
// on accept and popped when the block presents its output.
module tb_decode_prefix_stream;

    localparam int WB  = 12;
    localparam int MAX = 4;
    localparam int WW  = 8 * WB;
    localparam int CW  = $clog2(MAX + 1);

    typedef struct packed {
        logic [WW-1:0] win;
        logic          op16;
        logic          addr16;
        logic [1:0]    rep;
        logic          lock;
        logic [2:0]    seg;
        logic [CW-1:0] cnt;
        logic          err;
    } rec_t;

    typedef struct packed {
        rec_t rec;
        int   lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] in_window = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WW-1:0] out_window;
    logic          out_operand_16bit;
    logic          out_address_16bit;
    logic [1:0]    out_rep;
    logic          out_lock;
    logic [2:0]    out_seg;
    logic [CW-1:0] out_prefix_count;
    logic          out_error;

    int   compared = 0;
    int   failed   = 0;
    exp_t sb[$];

    decode_prefix_stream #(
        .WINDOW_BYTES(WB),
        .MAX_PREFIXES(MAX)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_window         (in_window),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_window        (out_window),
        .out_operand_16bit (out_operand_16bit),
        .out_address_16bit (out_address_16bit),
        .out_rep           (out_rep),
        .out_lock          (out_lock),
        .out_seg           (out_seg),
        .out_prefix_count  (out_prefix_count),
        .out_error         (out_error)
    );

    always #5 clk = ~clk;

    // Reference model of the prefix stripper for one window.
    function automatic exp_t model(input logic [WW-1:0] w);
        exp_t       e;
        logic [7:0] b;
        logic       isp;
        int         cnt;
        e   = '0;
        cnt = 0;
        for (int i = 0; i < WB; i++) begin
            b   = w[7:0];
            isp = 1'b1;
            case (b)
                8'h66: ;
                8'h67: ;
                8'hF0: ;
                8'hF2: ;
                8'hF3: ;
                8'h26: ;
                8'h2E: ;
                8'h36: ;
                8'h3E: ;
                8'h64: ;
                8'h65: ;
                default: isp = 1'b0;
            endcase
            if (!isp) break;
            if (cnt == MAX) begin
                e.rec.err = 1'b1;
                break;
            end
            case (b)
                8'h66: e.rec.op16   = 1'b1;
                8'h67: e.rec.addr16 = 1'b1;
                8'hF0: e.rec.lock   = 1'b1;
                8'hF3: e.rec.rep    = 2'd1;
                8'hF2: e.rec.rep    = 2'd2;
                8'h26: e.rec.seg    = 3'd1;
                8'h2E: e.rec.seg    = 3'd2;
                8'h36: e.rec.seg    = 3'd3;
                8'h3E: e.rec.seg    = 3'd4;
                8'h64: e.rec.seg    = 3'd5;
                8'h65: e.rec.seg    = 3'd6;
                default: ;
            endcase
            w   = w >> 8;
            cnt = cnt + 1;
        end
        e.rec.win = w;
        e.rec.cnt = CW'(cnt);
        e.lat     = cnt + 1;
        return e;
    endfunction

    function automatic rec_t obs_now();
        rec_t r;
        r.win    = out_window;
        r.op16   = out_operand_16bit;
        r.addr16 = out_address_16bit;
        r.rep    = out_rep;
        r.lock   = out_lock;
        r.seg    = out_seg;
        r.cnt    = out_prefix_count;
        r.err    = out_error;
        return r;
    endfunction

    // Build a window: low n bytes from lo, the rest random.
    function automatic logic [WW-1:0] mk(input logic [63:0] lo, input int n);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < WB; i++) begin
            if (i < n) w[8*i +: 8] = lo[8*i +: 8];
            else       w[8*i +: 8] = 8'($urandom);
        end
        return w;
    endfunction

    // Present a window until accepted, then record its expected result.
    task automatic send(input logic [WW-1:0] w);
        int waited;
        in_valid  = 1'b1;
        in_window = w;
        waited    = 0;
        while (waited < 40) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waited++;
        end
        compared++;
        if (waited >= 40) begin
            failed++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back(model(w));
    endtask

    // Wait for out_valid; lat counts clock edges from accept.
    task automatic receive(output rec_t obs, output int lat);
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            lat++;
        end
        compared++;
        if (lat >= 40) begin
            failed++;
            $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
        end
        obs = obs_now();
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({out_valid, obs_now()} !== '0) begin
            failed++;
            $display("FAIL reset_outputs: got valid=%b rec=%h, required all 0", out_valid, obs_now());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_window(input string name, input logic [63:0] lo, input int n, input int req_lat);
        rec_t obs;
        int   lat;
        exp_t e;
        send(mk(lo, n));
        receive(obs, lat);
        e = sb.pop_front();
        compared++;
        if (obs !== e.rec) begin
            failed++;
            $display("FAIL %s_record: got %h, required %h", name, obs, e.rec);
        end
        compared++;
        if (lat !== req_lat || lat !== e.lat) begin
            failed++;
            $display("FAIL %s_latency: got %0d, required %0d", name, lat, req_lat);
        end
        release_out();
    endtask

    task automatic test_no_prefix();
        test_window("no_prefix", 64'h08458B, 3, 1);
    endtask

    task automatic test_mixed();
        test_window("mixed", 64'hA52666F3, 4, 4);
    endtask

    task automatic test_last_wins();
        test_window("last_wins", 64'h90652EF3F2, 5, 5);
    endtask

    task automatic test_limit();
        test_window("limit", 64'h906666666666, 6, MAX + 1);
    endtask

    task automatic test_zero_window();
        rec_t obs;
        int   lat;
        exp_t e;
        send('0);
        receive(obs, lat);
        e = sb.pop_front();
        compared++;
        if (obs !== e.rec || lat !== 1) begin
            failed++;
            $display("FAIL zero_window: got %h lat %0d, required %h lat 1", obs, lat, e.rec);
        end
        release_out();
    endtask

    task automatic test_random();
        logic [7:0]    ptab [11];
        logic [WW-1:0] w;
        rec_t          obs;
        int            lat;
        exp_t          e;
        ptab = '{8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < WB; i++) begin
                if ($urandom_range(0, 9) < 7) w[8*i +: 8] = ptab[$urandom_range(0, 10)];
                else                          w[8*i +: 8] = 8'($urandom);
            end
            send(w);
            receive(obs, lat);
            e = sb.pop_front();
            compared++;
            if (obs !== e.rec || lat !== e.lat) begin
                failed++;
                $display("FAIL random_%0d: got %h lat %0d, required %h lat %0d", t, obs, lat, e.rec, e.lat);
            end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        rec_t          obs, first;
        int            lat;
        exp_t          e;
        logic [WW-1:0] wb;
        send(mk(64'h90F066, 3));
        receive(first, lat);
        e = sb.pop_front();
        compared++;
        if (first !== e.rec || lat !== 3) begin
            failed++;
            $display("FAIL b2b_first: got %h lat %0d, required %h lat 3", first, lat, e.rec);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = obs_now();
            compared++;
            if (out_valid !== 1'b1 || obs !== first) begin
                failed++;
                $display("FAIL b2b_stable_%0d: got valid=%b %h, required valid=1 %h", c, out_valid, obs, first);
            end
        end
        wb        = mk(64'hC3F364, 3);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_window = wb;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL b2b_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        sb.push_back(model(wb));
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failed++;
            $display("FAIL b2b_no_idle: got valid=%b in_ready=%b, required 0 0 (SCAN)", out_valid, in_ready);
        end
        receive(obs, lat);
        e = sb.pop_front();
        compared++;
        if (obs !== e.rec || lat !== 3) begin
            failed++;
            $display("FAIL b2b_second: got %h lat %0d, required %h lat 3", obs, lat, e.rec);
        end
        release_out();
    endtask

    task automatic test_flush();
        rec_t obs;
        int   lat;
        logic saw_valid;
        exp_t e;
        send(mk(64'h90F0F0F0, 4));
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        e = sb.pop_front();
        saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        compared++;
        if (saw_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL flush_scan: got saw_valid=%b in_ready=%b, required 0 1", saw_valid, in_ready);
        end
        @(posedge clk);
        #1;
        send(mk(64'h9066, 2));
        receive(obs, lat);
        e = sb.pop_front();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_window = mk(64'h90, 1);
        flush     = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin
            failed++;
            $display("FAIL flush_in_ready: got %b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL flush_hold: got valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_hold();
        rec_t obs;
        int   lat;
        exp_t e;
        send(mk(64'h90F36726, 4));
        receive(obs, lat);
        e = sb.pop_front();
        #1;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({out_valid, obs_now()} !== '0) begin
            failed++;
            $display("FAIL reset_hold: got valid=%b rec=%h, required all 0", out_valid, obs_now());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_hold_after: got valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_no_prefix();
        test_mixed();
        test_last_wins();
        test_limit();
        test_zero_window();
        test_back_to_back();
        test_flush();
        test_reset_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
